arb_rr8_ctrl: RTL and testbench

ARB_RR8_CTRL -- requirements
Module: arb_rr8_ctrl

---
 rtl/arb_rr8_ctrl_pkg.sv | 31 +++
 rtl/arb_rr8_ctrl_decoder_3to8.sv | 14 +
 rtl/arb_rr8_ctrl.sv | 86 ++++++++
 tb/tb_arb_rr8_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/arb_rr8_ctrl_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
// Holds the FSM state encoding, requester count and the rotating priority search.
package arb_rr8_ctrl_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // First set request bit found searching upward from ptr, wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/arb_rr8_ctrl_decoder_3to8.sv
// Combinational 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module decoder_3to8
  import arb_rr8_ctrl_pkg::*;
(
  input  logic               en,
  input  logic [IDX_W-1:0]   in,
  output logic [NUM_REQ-1:0] out
);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_dec
    assign out[gi] = en && (in == IDX_W'(gi));
  end

endmodule

// File: rtl/arb_rr8_ctrl.sv
// 8-way round-robin arbiter with done/req-drop/enable release and a hold-time limit.
// Grant state is fully registered; the one-hot vector is decoded from the registered index.
module arb_rr8_ctrl
  import arb_rr8_ctrl_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  localparam int                CNT_W    = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HOLD_MAX - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_valid;
  logic               r_timeout;

  logic [IDX_W-1:0]   w_winner;
  logic               w_expire;
  logic               w_early;
  logic               w_release;

  assign w_winner  = rr_pick(req, r_ptr);
  assign w_expire  = (r_cnt == CNT_LAST);
  // Any non-expiry cause suppresses the timeout pulse, even when expiry coincides.
  assign w_early   = done || !req[r_idx] || !en;
  assign w_release = w_early || w_expire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en && (|req)) begin
            r_state <= GRANT;
            r_idx   <= w_winner;
            r_valid <= 1'b1;
            r_cnt   <= '0;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_cnt     <= '0;
            r_ptr     <= r_idx + IDX_W'(1);
            r_timeout <= !w_early;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  decoder_3to8 u_dec (
    .en  (r_valid),
    .in  (r_idx),
    .out (gnt)
  );

  assign gnt_idx   = r_idx;
  assign gnt_valid = r_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_arb_rr8_ctrl.sv
// Directed bench for arb_rr8_ctrl (HOLD_MAX=4): vector table plus rotation and async-reset sequences.
module tb_arb_rr8_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arb_rr8_ctrl #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  typedef struct packed {
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       to;
  } vec_t;

  localparam int NV = 26;
  vec_t vec[NV];

  function automatic vec_t mk(input logic e, input logic [7:0] r, input logic d,
                              input logic [7:0] g, input logic [2:0] i,
                              input logic v, input logic t);
    vec_t x;
    x.en = e; x.req = r; x.done = d; x.gnt = g; x.idx = i; x.valid = v; x.to = t;
    return x;
  endfunction

  task automatic check_out(input string name, input logic [7:0] g, input logic [2:0] i,
                           input logic v, input logic t);
    n_vec++;
    if (gnt !== g || gnt_idx !== i || gnt_valid !== v || timeout !== t) begin
      n_err++;
      $display("FAIL %s: got gnt=%h idx=%0d valid=%b timeout=%b, want gnt=%h idx=%0d valid=%b timeout=%b",
               name, gnt, gnt_idx, gnt_valid, timeout, g, i, v, t);
    end else begin
      $display("ok   %s: gnt=%h idx=%0d valid=%b timeout=%b", name, gnt, gnt_idx, gnt_valid, timeout);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          en  req    done gnt    idx   v     to
    vec[0]  = mk(1, 8'h01, 0, 8'h01, 3'd0, 1'b1, 1'b0);
    vec[1]  = mk(1, 8'h01, 0, 8'h01, 3'd0, 1'b1, 1'b0);
    vec[2]  = mk(1, 8'h01, 1, 8'h00, 3'd0, 1'b0, 1'b0);
    vec[3]  = mk(1, 8'h03, 0, 8'h02, 3'd1, 1'b1, 1'b0);
    vec[4]  = mk(1, 8'h03, 1, 8'h00, 3'd0, 1'b0, 1'b0);
    vec[5]  = mk(0, 8'hFF, 0, 8'h00, 3'd0, 1'b0, 1'b0);
    vec[6]  = mk(0, 8'hFF, 0, 8'h00, 3'd0, 1'b0, 1'b0);
    vec[7]  = mk(1, 8'hFF, 1, 8'h04, 3'd2, 1'b1, 1'b0);
    vec[8]  = mk(1, 8'hFB, 0, 8'h00, 3'd0, 1'b0, 1'b0);
    vec[9]  = mk(1, 8'hFF, 0, 8'h08, 3'd3, 1'b1, 1'b0);
    vec[10] = mk(0, 8'hFF, 0, 8'h00, 3'd0, 1'b0, 1'b0);
    vec[11] = mk(1, 8'h10, 0, 8'h10, 3'd4, 1'b1, 1'b0);
    vec[12] = mk(1, 8'h10, 0, 8'h10, 3'd4, 1'b1, 1'b0);
    vec[13] = mk(1, 8'h10, 0, 8'h10, 3'd4, 1'b1, 1'b0);
    vec[14] = mk(1, 8'h10, 0, 8'h10, 3'd4, 1'b1, 1'b0);
    vec[15] = mk(1, 8'h10, 0, 8'h00, 3'd0, 1'b0, 1'b1);
    vec[16] = mk(1, 8'h10, 0, 8'h10, 3'd4, 1'b1, 1'b0);
    vec[17] = mk(1, 8'h10, 0, 8'h10, 3'd4, 1'b1, 1'b0);
    vec[18] = mk(1, 8'h10, 0, 8'h10, 3'd4, 1'b1, 1'b0);
    vec[19] = mk(1, 8'h10, 0, 8'h10, 3'd4, 1'b1, 1'b0);
    vec[20] = mk(1, 8'h10, 1, 8'h00, 3'd0, 1'b0, 1'b0);
    vec[21] = mk(1, 8'h81, 0, 8'h80, 3'd7, 1'b1, 1'b0);
    vec[22] = mk(1, 8'h81, 1, 8'h00, 3'd0, 1'b0, 1'b0);
    vec[23] = mk(1, 8'h81, 0, 8'h01, 3'd0, 1'b1, 1'b0);
    vec[24] = mk(1, 8'hC1, 0, 8'h01, 3'd0, 1'b1, 1'b0);
    vec[25] = mk(1, 8'hC1, 1, 8'h00, 3'd0, 1'b0, 1'b0);

    // Reset state while rst is held, before any clock edge.
    #2;
    check_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_out("reset_held", 8'h00, 3'd0, 1'b0, 1'b0);
    #3 rst = 1'b0;

    for (int k = 0; k < NV; k++) begin
      en = vec[k].en; req = vec[k].req; done = vec[k].done;
      step();
      check_out($sformatf("vec%0d", k), vec[k].gnt, vec[k].idx, vec[k].valid, vec[k].to);
    end

    // Rotation from a fresh reset: grants 0..7,0 with one idle cycle between.
    en = 1'b1; req = 8'hFF; done = 1'b0;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      logic [7:0] one_hot;
      one_hot = 8'h01 << (k % 8);
      done = 1'b0;
      step();
      check_out($sformatf("rot%0d_grant", k), one_hot, 3'(k % 8), 1'b1, 1'b0);
      done = 1'b1;
      step();
      check_out($sformatf("rot%0d_idle", k), 8'h00, 3'd0, 1'b0, 1'b0);
    end

    // Asynchronous reset between edges during a grant.
    done = 1'b0; req = 8'hFF; en = 1'b1;
    step();
    check_out("pre_rst_grant", 8'h02, 3'd1, 1'b1, 1'b0);
    #3 rst = 1'b1;
    #1;
    check_out("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    step();
    check_out("post_rst_grant", 8'h01, 3'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
